// File: rtl/imm_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word, expands `li`.
// Define IMM_RANGE_CHECK_EN to build the immediate range/alignment checks that drive out_err.
module imm_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_fmt,
    input  logic        in_li,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, LI2 = 2'd2} state_e;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d, addi_q, addi_d;
    logic        err_q, err_d, pend_q, pend_d;
    logic [31:0] enc_instr, enc_addi;
    logic        enc_err, enc_pend;
    logic [19:0] li_hi;
    logic        li_small, in_fire, out_fire;

    // (imm + 0x800)[31:12]: the low-half add only carries out when imm[11] is set
    assign li_hi    = in_imm[31:12] + {19'd0, in_imm[11]};
    assign li_small = (in_imm[31:11] == {21{in_imm[11]}});

    always_comb begin
        enc_instr = {7'b0, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc_addi  = {in_imm[11:0], in_rd, 3'b000, in_rd, 7'h13};
        enc_pend  = 1'b0;
        if (in_li) begin
            if (li_small) begin
                enc_instr = {in_imm[11:0], 5'd0, 3'b000, in_rd, 7'h13};
            end else begin
                enc_instr = {li_hi, in_rd, 7'h37};
                enc_pend  = (in_imm[11:0] != 12'd0);
            end
        end else if (in_fmt[0]) begin
            enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        end else if (in_fmt[1]) begin
            enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        end else if (in_fmt[2]) begin
            enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], in_opcode};
        end else if (in_fmt[3]) begin
            enc_instr = {in_imm[31:12], in_rd, in_opcode};
        end else if (in_fmt[4]) begin
            enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    always_comb begin
        enc_err = 1'b0;
        if (!in_li) begin
            if (in_fmt[0] || in_fmt[1]) begin
                enc_err = !li_small;
            end else if (in_fmt[2]) begin
                enc_err = (in_imm[31:12] != {20{in_imm[12]}}) || in_imm[0];
            end else if (in_fmt[3]) begin
                enc_err = (in_imm[11:0] != 12'd0);
            end else if (in_fmt[4]) begin
                enc_err = (in_imm[31:20] != {12{in_imm[20]}}) || in_imm[0];
            end
        end
    end
`else
    assign enc_err = 1'b0;
`endif

    assign out_valid = (state_q != IDLE);
    assign out_instr = instr_q;
    assign out_err   = err_q;
    assign busy      = (state_q == LI2);
    assign in_ready  = (state_q != LI2) && (!out_valid || out_ready) && !pend_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        addi_d  = addi_q;
        err_d   = err_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE, EMIT: begin
                if (out_fire && pend_q) begin
                    state_d = LI2;
                    instr_d = addi_q;
                    err_d   = 1'b0;
                    pend_d  = 1'b0;
                end else if (in_fire) begin
                    state_d = EMIT;
                    instr_d = enc_instr;
                    addi_d  = enc_addi;
                    err_d   = enc_err;
                    pend_d  = enc_pend;
                end else if (out_fire) begin
                    state_d = IDLE;
                end
            end
            LI2: if (out_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            instr_q <= 32'd0;
            addi_q  <= 32'd0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            addi_q  <= addi_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed cases plus random requests vs. a field-level model.
module tb_imm_encoder;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_li, out_valid, out_ready, out_err, busy;
    logic [4:0]  in_fmt, in_rd, in_rs1, in_rs2;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm, out_instr;
    int          checks = 0, errors = 0;
    logic [31:0] first_word, second_word;

    imm_encoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_li(in_li), .in_opcode(in_opcode), .in_funct3(in_funct3),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Builds each field from the bit lists of the instruction formats.
    function automatic logic [31:0] enc_ref(input logic [4:0] fmt, input logic [6:0] op,
                                            input logic [2:0] f3, input logic [4:0] rd, rs1, rs2,
                                            input logic [31:0] imm);
        logic [31:0] w = 32'd0;
        int sel = 5;
        for (int b = 4; b >= 0; b--) if (fmt[b]) sel = b;
        w[6:0] = op;
        case (sel)
            0: begin w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1; w[31:20] = imm[11:0]; end
            1: begin w[11:7] = imm[4:0]; w[14:12] = f3; w[19:15] = rs1; w[24:20] = rs2;
                     w[31:25] = imm[11:5]; end
            2: begin w[7] = imm[11]; w[11:8] = imm[4:1]; w[14:12] = f3; w[19:15] = rs1;
                     w[24:20] = rs2; w[30:25] = imm[10:5]; w[31] = imm[12]; end
            3: begin w[11:7] = rd; w[31:12] = imm[31:12]; end
            4: begin w[11:7] = rd; w[19:12] = imm[19:12]; w[20] = imm[11]; w[30:21] = imm[10:1];
                     w[31] = imm[20]; end
            default: begin w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1; w[24:20] = rs2; end
        endcase
        return w;
    endfunction

    function automatic logic err_ref(input logic [4:0] fmt, input logic [31:0] imm);
        int s = int'(imm);
        int sel = 5;
        for (int b = 4; b >= 0; b--) if (fmt[b]) sel = b;
`ifdef IMM_RANGE_CHECK_EN
        case (sel)
            0, 1: return (s < -2048) || (s > 2047);
            2:    return (s < -4096) || (s > 4094) || (s % 2 != 0);
            3:    return (imm % 4096) != 0;
            4:    return (s < -1048576) || (s > 1048574) || (s % 2 != 0);
            default: return 1'b0;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    task automatic build_exp(input logic li, input logic [4:0] fmt, input logic [6:0] op,
                             input logic [2:0] f3, input logic [4:0] rd, rs1, rs2,
                             input logic [31:0] imm, output int n, output logic [31:0] w0, w1,
                             output logic e);
        int s = int'(imm);
        int unsigned hi, lo;
        n = 1; w1 = 32'd0; e = 1'b0;
        if (li) begin
            if (s >= -2048 && s <= 2047) begin
                w0 = ((imm & 32'hFFF) << 20) + (32'(rd) << 7) + 32'h13;
            end else begin
                hi = (imm + 32'h800) >> 12;
                lo = imm & 32'hFFF;
                w0 = (hi << 12) + (32'(rd) << 7) + 32'h37;
                if (lo != 0) begin
                    n  = 2;
                    w1 = (lo << 20) + (32'(rd) << 15) + (32'(rd) << 7) + 32'h13;
                end
            end
        end else begin
            w0 = enc_ref(fmt, op, f3, rd, rs1, rs2, imm);
            e  = err_ref(fmt, imm);
        end
    endtask

    task automatic set_req(input logic li, input logic [4:0] fmt, input logic [6:0] op,
                           input logic [2:0] f3, input logic [4:0] rd, rs1, rs2,
                           input logic [31:0] imm);
        in_li = li; in_fmt = fmt; in_opcode = op; in_funct3 = f3;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    // Called at posedge+1 with the DUT idle; stall = cycles of out_ready=0 per beat.
    task automatic run(input logic li, input logic [4:0] fmt, input logic [6:0] op,
                       input logic [2:0] f3, input logic [4:0] rd, rs1, rs2,
                       input logic [31:0] imm, input int stall);
        int n, wait_n;
        logic [31:0] w[2];
        logic e;
        build_exp(li, fmt, op, f3, rd, rs1, rs2, imm, n, w[0], w[1], e);
        set_req(li, fmt, op, f3, rd, rs1, rs2, imm);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        wait_n = 0;
        while (!in_ready && wait_n < 10) begin @(posedge clk); #1; wait_n++; end
        chk("accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            out_ready = 1'b0;
            for (int k = 0; k < stall; k++) begin
                #1;
                chk("stall_instr", out_instr, w[i]);
                chk("stall_ready", {31'd0, in_ready}, 32'd0);
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            #1;
            chk("valid", {31'd0, out_valid}, 32'd1);
            chk("instr", out_instr, w[i]);
            chk("err", {31'd0, out_err}, {31'd0, e});
            chk("busy", {31'd0, busy}, (i == 1) ? 32'd1 : 32'd0);
            chk("in_ready", {31'd0, in_ready}, (n == 2) ? 32'd0 : 32'd1);
            if (i == 0) first_word = out_instr; else second_word = out_instr;
            @(posedge clk); #1;
        end
        chk("drained", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] hold_w, imm_r;
        int mode;
        logic [31:0] bnd[10];
        bnd = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4096,
                -32'sd4096, 32'd1048574, -32'sd1048576, 32'd1048576};
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_req(1'b0, 5'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_err", {31'd0, out_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run(1'b0, 5'b00001, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 0);
        chk("plan_i", first_word, 32'hFFF00093);
        run(1'b0, 5'b00100, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8, 0);
        chk("plan_b", first_word, 32'h00208463);
        run(1'b0, 5'b10000, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFC, 0);
        chk("plan_j", first_word, 32'hFFDFF0EF);
        run(1'b1, 5'd0, 7'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF, 0);
        chk("plan_li_lui", first_word, 32'h123462B7);
        chk("plan_li_addi", second_word, 32'hFFF28293);
        run(1'b1, 5'd0, 7'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h0001_2000, 0);
        chk("plan_li_one", first_word, 32'h000122B7);
        run(1'b0, 5'b00001, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 0);
        chk("plan_i_2048", first_word, 32'h80000093);

        // Backpressure: five stalled cycles, then a new request taken on release.
        set_req(1'b0, 5'b00001, 7'h13, 3'd2, 5'd3, 5'd4, 5'd0, 32'd5);
        hold_w = enc_ref(5'b00001, 7'h13, 3'd2, 5'd3, 5'd4, 5'd0, 32'd5);
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        set_req(1'b0, 5'b00010, 7'h23, 3'd2, 5'd0, 5'd6, 5'd7, 32'hFFFF_FF80);
        repeat (5) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_instr", out_instr, hold_w);
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_next", out_instr, enc_ref(5'b00010, 7'h23, 3'd2, 5'd0, 5'd6, 5'd7, 32'hFFFF_FF80));
        @(posedge clk); #1;
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // Reset while the ADDI beat of an `li` is on the output.
        set_req(1'b1, 5'd0, 7'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rli_lui", out_instr, 32'h123462B7);
        @(posedge clk); #1;
        chk("rli_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rli_valid", {31'd0, out_valid}, 32'd0);
        chk("rli_busy0", {31'd0, busy}, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rli_no_addi", {31'd0, out_valid}, 32'd0);
        chk("rli_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("rli_idle", {31'd0, out_valid}, 32'd0);

        for (int t = 0; t < 80; t++) begin
            mode = $urandom_range(0, 4);
            case (mode)
                0: imm_r = 32'($urandom_range(0, 4095)) - 32'd2048;
                1: imm_r = $urandom;
                2: imm_r = 32'($urandom_range(0, 16383)) - 32'd8192;
                3: imm_r = $urandom & 32'hFFFF_F000;
                default: imm_r = bnd[$urandom_range(0, 9)];
            endcase
            run(($urandom_range(0, 3) == 0), 5'($urandom), 7'($urandom), 3'($urandom),
                5'($urandom), 5'($urandom), 5'($urandom), imm_r, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
